ahb_gpio_slave: RTL and testbench

//  AHB slave GPIO peripheral at BASE_ADDR (0x2020_0000-0x2020_000F); responder for bus-master GPIO traffic.

---
 rtl/ahb_gpio_slave_if.sv | 25 ++
 rtl/ahb_gpio_slave.sv | 144 ++++++++++++++
 tb/tb_ahb_gpio_slave.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_gpio_slave_if.sv
// AHB-Lite bus bundle for the GPIO slave: address/control, write data and the slave response.
interface ahb_gpio_slave_if;
    logic        HSELx;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [3:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_gpio_slave.sv
// AHB GPIO slave: DIR/DOUT/DIN/IRQ_STAT registers, zero-wait OKAY, two-cycle ERROR response.
// Optional edge interrupt built only when GPIO_IRQ_EN is defined.
module ahb_gpio_slave #(
    parameter int unsigned GPIO_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h2020_0000
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_gpio_slave_if.slave   bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

    state_t            state;
    logic              dp_valid;
    logic              dp_write;
    logic [1:0]        dp_off;
    logic              readyout;
    logic [1:0]        resp;
    logic [GPIO_W-1:0] reg_dir;
    logic [GPIO_W-1:0] reg_dout;
    logic [GPIO_W-1:0] sync1;
    logic [GPIO_W-1:0] sync2;
    logic [GPIO_W-1:0] irq_stat;
    logic [31:0]       rd_val;

    logic addr_ok;
    logic addr_err;
    logic wr_commit;

    assign addr_ok   = bus.HSELx & bus.HREADY & bus.HTRANS[1];
    assign addr_err  = (bus.HSIZE != 4'd2) || (bus.HADDR[1:0] != 2'b00) ||
                       (bus.HADDR[31:4] != BASE_ADDR[31:4]);
    assign wr_commit = dp_valid & dp_write & bus.HREADY;

    // dp_valid only marks legal transfers; errored ones live entirely in the ERR1/ERR2 states.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_OKAY;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= 2'd0;
            readyout <= 1'b1;
            resp     <= RESP_OKAY;
        end else begin
            case (state)
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    readyout <= 1'b1;
                    resp     <= RESP_ERROR;
                end
                default: begin
                    dp_valid <= addr_ok & ~addr_err;
                    dp_write <= bus.HWRITE;
                    dp_off   <= bus.HADDR[3:2];
                    if (addr_ok && addr_err) begin
                        state    <= ST_ERR1;
                        readyout <= 1'b0;
                        resp     <= RESP_ERROR;
                    end else begin
                        state    <= ST_OKAY;
                        readyout <= 1'b1;
                        resp     <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            reg_dir  <= '0;
            reg_dout <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (wr_commit) begin
                case (dp_off)
                    2'd0:    reg_dir  <= bus.HWDATA[GPIO_W-1:0];
                    2'd1:    reg_dout <= bus.HWDATA[GPIO_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_W-1:0] sync3;
    logic [GPIO_W-1:0] irq_set;
    logic [GPIO_W-1:0] irq_clr;
    logic [GPIO_W-1:0] irq_next;
    logic              irq_r;

    // Set has priority over a same-cycle W1C so no edge is ever dropped.
    assign irq_set  = sync2 & ~sync3 & ~reg_dir;
    assign irq_clr  = (wr_commit && dp_off == 2'd3) ? bus.HWDATA[GPIO_W-1:0] : '0;
    assign irq_next = (irq_stat & ~irq_clr) | irq_set;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync3    <= '0;
            irq_stat <= '0;
            irq_r    <= 1'b0;
        end else begin
            sync3    <= sync2;
            irq_stat <= irq_next;
            irq_r    <= |irq_next;
        end
    end

    assign irq = irq_r;
`else
    assign irq_stat = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (dp_off)
            2'd0:    rd_val[GPIO_W-1:0] = reg_dir;
            2'd1:    rd_val[GPIO_W-1:0] = reg_dout;
            2'd2:    rd_val[GPIO_W-1:0] = sync2;
            default: rd_val[GPIO_W-1:0] = irq_stat;
        endcase
    end

    // Read data comes straight from the registers, so a write followed by a read needs no stall.
    assign bus.HRDATA    = (dp_valid && !dp_write) ? rd_val : 32'h0;
    assign bus.HREADYOUT = readyout;
    assign bus.HRESP     = resp;
    assign gpio_out      = reg_dout;
    assign gpio_oe       = reg_dir;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.HBURST, bus.HPROT, bus.HWDATA};
endmodule

// File: tb/tb_ahb_gpio_slave.sv
// Bench for ahb_gpio_slave: per-cycle transaction-level model plus directed literal checks.
module tb_ahb_gpio_slave;
    localparam int          GPIO_W = 16;
    localparam logic [31:0] BASE   = 32'h2020_0000;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic              HCLK = 1'b0;
    logic              HRESET = 1'b1;
    logic [GPIO_W-1:0] gpio_in = '0;
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_oe;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_gpio_slave_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_gpio_slave #(.GPIO_W(GPIO_W), .BASE_ADDR(BASE)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [GPIO_W-1:0] m_dir = '0, m_dout = '0, m_stat = '0;
    logic [GPIO_W-1:0] m_h0 = '0, m_h1 = '0, m_h2 = '0;   // gpio_in as sampled 1, 2, 3 edges ago
    bit                m_on = 0, m_dp = 0, m_dp_err = 0, m_dp_wr = 0, m_err2 = 0;
    logic [1:0]        m_off = '0;

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return 32'(m_dir);
            2'd1:    return 32'(m_dout);
            2'd2:    return 32'(m_h1);
            default: return 32'(m_stat);
        endcase
    endfunction

    always @(negedge HCLK) begin : model
        logic              e_rdy;
        logic [1:0]        e_resp;
        logic [31:0]       e_rd;
        logic [GPIO_W-1:0] set_v, clr_v;
        e_rdy  = !(m_dp && m_dp_err && !m_err2);
        e_resp = (m_dp && m_dp_err) ? 2'b01 : 2'b00;
        e_rd   = (m_dp && !m_dp_err && !m_dp_wr) ? m_read(m_off) : 32'h0;
        if (m_on) begin
            chk("HREADYOUT", 32'(bus.HREADYOUT), 32'(e_rdy));
            chk("HRESP", 32'(bus.HRESP), 32'(e_resp));
            chk("HRDATA", bus.HRDATA, e_rd);
            chk("gpio_out", 32'(gpio_out), 32'(m_dout));
            chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
            chk("irq", 32'(irq), 32'(|m_stat));
        end
        if (HRESET) begin
            m_dir = '0; m_dout = '0; m_stat = '0;
            m_h0 = '0; m_h1 = '0; m_h2 = '0;
            m_dp = 0; m_err2 = 0; m_on = 1;
        end else begin
            set_v = m_h1 & ~m_h2 & ~m_dir;
            clr_v = '0;
            if (m_dp && !m_dp_err && m_dp_wr) begin
                case (m_off)
                    2'd0:    m_dir  = bus.HWDATA[GPIO_W-1:0];
                    2'd1:    m_dout = bus.HWDATA[GPIO_W-1:0];
                    2'd3:    clr_v  = bus.HWDATA[GPIO_W-1:0];
                    default: ;
                endcase
            end
            m_stat = IRQ_EN ? ((m_stat & ~clr_v) | set_v) : '0;
            if (m_dp && m_dp_err && !m_err2) begin
                m_err2 = 1;
            end else begin
                m_dp     = bus.HSELx && bus.HTRANS[1];
                m_dp_err = (bus.HSIZE != 4'd2) || (bus.HADDR[1:0] != 2'b00) ||
                           (bus.HADDR[31:4] != BASE[31:4]);
                m_dp_wr  = bus.HWRITE;
                m_off    = bus.HADDR[3:2];
                m_err2   = 0;
            end
            m_h2 = m_h1; m_h1 = m_h0; m_h0 = gpio_in;
        end
    end

    // ---------------- bus master ----------------
    logic [31:0] t_addr[32], t_wdata[32], g_rdata[32];
    logic        t_write[32], t_sel[32];
    logic [3:0]  t_size[32];
    logic [1:0]  t_trans[32], g_resp[32];
    int          g_wait[32];
    bit          rand_gpio = 0;

    task automatic set_x(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        t_addr[i] = a; t_write[i] = w; t_wdata[i] = d;
        t_size[i] = 4'd2; t_trans[i] = 2'b10; t_sel[i] = 1'b1;
    endtask

    task automatic bus_idle();
        bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = 32'h0;
        bus.HSIZE = 4'd2; bus.HWDATA = 32'h0;
    endtask

    // Call at posedge+1; returns at posedge+1 after the last data phase has ended.
    task automatic run_seq(input int n);
        int   ap, dp, guard;
        logic rdy;
        ap = 0; dp = -1; guard = 0;
        for (int k = 0; k < n; k++) g_wait[k] = 0;
        while (ap < n || dp >= 0) begin
            if (ap < n) begin
                bus.HSELx = t_sel[ap]; bus.HADDR = t_addr[ap]; bus.HWRITE = t_write[ap];
                bus.HSIZE = t_size[ap]; bus.HTRANS = t_trans[ap];
            end else begin
                bus.HSELx = 1'b0; bus.HTRANS = 2'b00;
            end
            bus.HWDATA = (dp >= 0) ? t_wdata[dp] : 32'h0;
            if (rand_gpio && $urandom_range(3) == 0) gpio_in = GPIO_W'($urandom);
            @(negedge HCLK);
            rdy = bus.HREADYOUT;
            if (dp >= 0) begin
                if (rdy) begin g_rdata[dp] = bus.HRDATA; g_resp[dp] = bus.HRESP; end
                else g_wait[dp]++;
            end
            @(posedge HCLK); #1;
            if (rdy) begin
                dp = (ap < n) ? ap : -1;
                if (ap < n) ap++;
            end
            guard++;
            if (guard > 4 * n + 10) begin
                n_tests++; n_fail++;
                $display("FAIL run_seq_timeout: got %0d cycles expected <= %0d", guard, 4 * n + 10);
                break;
            end
        end
        bus_idle();
    endtask

    task automatic do_reset(input int cycles);
        HRESET = 1'b1;
        repeat (cycles) @(posedge HCLK);
        #1 HRESET = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        bus.HBURST = 3'b000; bus.HPROT = 4'b0011;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_oe", 32'(gpio_oe), 32'h0);
        chk("rst_out", 32'(gpio_out), 32'h0);
        chk("rst_ready", 32'(bus.HREADYOUT), 32'h1);
        chk("rst_resp", 32'(bus.HRESP), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(posedge HCLK); #1;

        // Pipelined writes
        set_x(0, 1, BASE + 0, 32'h5);    set_x(1, 1, BASE + 4, 32'h5555);
        set_x(2, 1, BASE + 0, 32'h3);    set_x(3, 1, BASE + 4, 32'h7855);
        run_seq(4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_resp", 32'(g_resp[i]), 32'h0);
            chk("wr_wait", 32'(g_wait[i]), 32'h0);
        end
        @(negedge HCLK);
        chk("wr_oe", 32'(gpio_oe), 32'h3);
        chk("wr_out", 32'(gpio_out), 32'h7855);
        @(posedge HCLK); #1;

        // Back-to-back reads, then write-then-read
        set_x(0, 0, BASE + 0, 0); set_x(1, 0, BASE + 4, 0);
        run_seq(2);
        chk("rd_dir", g_rdata[0], 32'h3);
        chk("rd_dout", g_rdata[1], 32'h7855);
        set_x(0, 1, BASE + 4, 32'hAAAA); set_x(1, 0, BASE + 4, 0);
        run_seq(2);
        chk("wr_rd_fwd", g_rdata[1], 32'hAAAA);

        // Synchroniser latency
        gpio_in = 16'h00F0;
        set_x(0, 0, BASE + 8, 0);
        run_seq(1);
        chk("din_early", g_rdata[0], 32'h0);
        repeat (3) @(posedge HCLK);
        #1 run_seq(1);
        chk("din_late", g_rdata[0], 32'hF0);

        // Error responses: unaligned, bad size, outside the window
        set_x(0, 1, BASE + 2, 32'h1111);
        set_x(1, 1, BASE + 4, 32'h1111); t_size[1] = 4'd0;
        set_x(2, 1, BASE + 32'h10, 32'h1111);
        for (int i = 0; i < 3; i++) begin
            set_x(31, 0, 0, 0);
            t_addr[0] = t_addr[i]; t_size[0] = t_size[i];
            run_seq(1);
            chk("err_resp", 32'(g_resp[0]), 32'h1);
            chk("err_wait", 32'(g_wait[0]), 32'h1);
            set_x(1, 1, BASE + 4, 32'h1111); t_size[1] = 4'd0;
            set_x(2, 1, BASE + 32'h10, 32'h1111);
        end
        @(negedge HCLK);
        chk("err_out", 32'(gpio_out), 32'hAAAA);
        chk("err_oe", 32'(gpio_oe), 32'h3);
        @(posedge HCLK); #1;

        // Transfer presented during ERR2 proceeds normally
        set_x(0, 1, BASE + 6, 32'h9999); set_x(1, 1, BASE + 4, 32'h1357); set_x(2, 0, BASE + 4, 0);
        run_seq(3);
        chk("err2_ok_resp", 32'(g_resp[1]), 32'h0);
        chk("err2_ok_rd", g_rdata[2], 32'h1357);

        // Reset during a write data phase loses the write
        bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = BASE + 4; bus.HSIZE = 4'd2;
        @(posedge HCLK); #1;
        bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h1234; HRESET = 1'b1;
        @(posedge HCLK); #1 HRESET = 1'b0;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("rst_abort_out", 32'(gpio_out), 32'h0);
        @(posedge HCLK); #1;
        bus_idle();

        // Reset during ERR1 returns to OKAY
        bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = BASE + 1;
        @(posedge HCLK); #1;
        bus_idle(); HRESET = 1'b1;
        @(posedge HCLK); #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_err_ready", 32'(bus.HREADYOUT), 32'h1);
        chk("rst_err_resp", 32'(bus.HRESP), 32'h0);
        @(posedge HCLK); #1;

`ifdef GPIO_IRQ_EN
        gpio_in = '0;
        set_x(0, 1, BASE + 0, 32'h0);
        run_seq(1);
        repeat (4) @(posedge HCLK);
        #1 set_x(0, 1, BASE + 32'hC, 32'hFFFF);
        run_seq(1);
        @(negedge HCLK);
        chk("irq_cleared", 32'(irq), 32'h0);
        @(posedge HCLK); #1 gpio_in = 16'h0008;
        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        chk("irq_set", 32'(irq), 32'h1);
        @(posedge HCLK); #1 set_x(0, 0, BASE + 32'hC, 0);
        run_seq(1);
        chk("irq_stat_rd", g_rdata[0], 32'h8);
        set_x(0, 1, BASE + 32'hC, 32'h8);
        run_seq(1);
        @(negedge HCLK);
        chk("irq_w1c", 32'(irq), 32'h0);
        @(posedge HCLK); #1 gpio_in = '0;
        repeat (4) @(posedge HCLK);
        #1 set_x(0, 1, BASE + 32'hC, 32'hFFFF);
        run_seq(1);
        gpio_in = 16'h0008;
        @(posedge HCLK); #1 set_x(0, 1, BASE + 32'hC, 32'h8);
        run_seq(1);
        @(negedge HCLK);
        chk("irq_set_wins", 32'(irq), 32'h1);
        @(posedge HCLK); #1 set_x(0, 0, BASE + 32'hC, 0);
        run_seq(1);
        chk("irq_set_wins_rd", g_rdata[0], 32'h8);
`else
        gpio_in = 16'h00FF;
        set_x(0, 1, BASE + 0, 32'h0);
        run_seq(1);
        repeat (4) @(posedge HCLK);
        #1 set_x(0, 1, BASE + 32'hC, 32'hFFFF); set_x(1, 0, BASE + 32'hC, 0);
        run_seq(2);
        chk("noirq_resp", 32'(g_resp[0]), 32'h0);
        chk("noirq_rd", g_rdata[1], 32'h0);
        @(negedge HCLK);
        chk("noirq_irq", 32'(irq), 32'h0);
        @(posedge HCLK); #1;
`endif

        // Randomised traffic against the model
        rand_gpio = 1;
        for (int blk = 0; blk < 30; blk++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] a;
                int          r;
                r = int'($urandom_range(15));
                a = BASE | (32'($urandom_range(3)) << 2);
                if (r == 0) a = $urandom;
                if (r == 1) a[1:0] = 2'($urandom_range(3, 1));
                t_addr[i]  = a;
                t_write[i] = 1'($urandom_range(1));
                t_wdata[i] = $urandom;
                t_size[i]  = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'd2;
                t_trans[i] = ($urandom_range(5) == 0) ? 2'($urandom_range(1)) : 2'($urandom_range(3, 2));
                t_sel[i]   = ($urandom_range(9) != 0);
            end
            run_seq(16);
            if (blk % 10 == 9) do_reset(1);
        end
        rand_gpio = 0;

        repeat (3) @(posedge HCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
